// File: rtl/iic_seq_ctrl_if.sv
// Host request/status and I2C core register-port signals of the write sequencer.
// master is the sequencer side; slave is the host requester together with the I2C core.
interface iic_seq_ctrl_if #(
    parameter int NBYTES = 4
);
    logic                  req_valid;
    logic                  req_ready;
    logic [6:0]            req_addr;
    logic [2:0]            req_len;
    logic [8*NBYTES-1:0]   req_data;
    logic                  busy;
    logic                  done;
    logic                  err;
    logic [1:0]            err_code;
    logic [1:0]            core_adr;
    logic [7:0]            core_data;
    logic                  core_cs;
    logic                  core_next;
    logic [7:0]            core_sr;

    modport master (
        input  req_valid, req_addr, req_len, req_data, core_sr,
        output req_ready, busy, done, err, err_code,
        output core_adr, core_data, core_cs, core_next
    );

    modport slave (
        output req_valid, req_addr, req_len, req_data, core_sr,
        input  req_ready, busy, done, err, err_code,
        input  core_adr, core_data, core_cs, core_next
    );
endinterface

// File: rtl/iic_seq_ctrl.sv
// Runs one I2C write (address + 1..NBYTES data bytes) through the I2C core register port,
// including SR polling, next pulses, NACK/timeout handling and stop.
module iic_seq_ctrl #(
    parameter int NBYTES  = 4,
    parameter int TIMEOUT = 1023
) (
    input logic            clk,
    input logic            rst_n,
    iic_seq_ctrl_if.master bus
);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] T_MAX   = TW'(TIMEOUT);
    localparam logic [3:0]    LEN_MAX = 4'(NBYTES);

    localparam logic [1:0] ADR_TXR = 2'b00;
    localparam logic [1:0] ADR_SR  = 2'b10;
    localparam logic [1:0] ADR_CTR = 2'b11;

    localparam logic [7:0] SR_IDLE  = 8'h00;
    localparam logic [7:0] SR_START = 8'h09;
    localparam logic [7:0] SR_DATA  = 8'h0A;
    localparam logic [7:0] SR_ACK   = 8'h08;
    localparam logic [7:0] SR_STOP  = 8'h0C;

    typedef enum logic [3:0] {
        S_IDLE, S_LD_ADDR, S_SET_START, S_W_DATA, S_W_ACK, S_LD_BYTE,
        S_NEXT, S_STOP, S_W_IDLE, S_FIN, S_ABORT
    } state_t;

    state_t              state_q, state_d;
    logic [6:0]          addr_q, addr_d;
    logic [2:0]          len_q, len_d;
    logic [2:0]          idx_q, idx_d;
    logic [8*NBYTES-1:0] buf_q, buf_d;
    logic [TW-1:0]       cnt_q, cnt_d;
    logic                seen_q, seen_d;
    logic [1:0]          err_code_q, err_code_d;
    logic                req_ready_q, req_ready_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic [1:0]          core_adr_q, core_adr_d;
    logic [7:0]          core_data_q, core_data_d;
    logic                core_cs_q, core_cs_d;
    logic                core_next_q, core_next_d;

    logic len_ok, accept, bad_req, in_wait, sr_valid, timed_out, nack_now;

    assign len_ok    = (bus.req_len != 3'd0) && ({1'b0, bus.req_len} <= LEN_MAX);
    assign accept    = req_ready_q && bus.req_valid && len_ok;
    assign bad_req   = req_ready_q && bus.req_valid && !len_ok;
    assign in_wait   = (state_q == S_W_DATA) || (state_q == S_W_ACK) || (state_q == S_W_IDLE);
    // The first SR sample after entering a wait state still reflects the previous register read.
    assign sr_valid  = (cnt_q != '0);
    assign timed_out = in_wait && (cnt_q == T_MAX);
    assign nack_now  = (state_q == S_W_ACK) && !timed_out && seen_q && (bus.core_sr == SR_STOP);

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      if (accept) state_d = S_LD_ADDR;
            S_LD_ADDR:   state_d = S_SET_START;
            S_SET_START: state_d = S_W_DATA;
            S_W_DATA: begin
                if (timed_out)
                    state_d = S_ABORT;
                else if (sr_valid && (bus.core_sr == SR_DATA || bus.core_sr == SR_ACK))
                    state_d = S_W_ACK;
            end
            S_W_ACK: begin
                if (timed_out)
                    state_d = S_ABORT;
                else if (seen_q && bus.core_sr == SR_START)
                    state_d = (idx_q != len_q) ? S_LD_BYTE : S_STOP;
                else if (nack_now)
                    state_d = S_STOP;
            end
            S_LD_BYTE:   state_d = S_NEXT;
            S_NEXT:      state_d = S_W_DATA;
            S_STOP:      state_d = S_W_IDLE;
            S_W_IDLE: begin
                if (timed_out)
                    state_d = S_ABORT;
                else if (sr_valid && bus.core_sr == SR_IDLE)
                    state_d = S_FIN;
            end
            S_FIN:       state_d = S_IDLE;
            S_ABORT:     state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    always_comb begin
        addr_d     = addr_q;
        len_d      = len_q;
        idx_d      = idx_q;
        buf_d      = buf_q;
        err_code_d = err_code_q;
        cnt_d      = '0;
        seen_d     = 1'b0;
        if (accept) begin
            addr_d     = bus.req_addr;
            len_d      = bus.req_len;
            buf_d      = bus.req_data;
            idx_d      = 3'd0;
            err_code_d = 2'b00;
        end
        if (bad_req)
            err_code_d = 2'b11;
        // Byte 0 of the buffer is always the next byte to send.
        if (state_q == S_NEXT) begin
            buf_d = buf_q >> 8;
            idx_d = idx_q + 3'd1;
        end
        if (nack_now)
            err_code_d = 2'b01;
        if (state_d == S_ABORT)
            err_code_d = 2'b10;
        if (in_wait && state_d == state_q)
            cnt_d = cnt_q + 1'b1;
        if (state_q == S_W_ACK && state_d == S_W_ACK)
            seen_d = seen_q | (sr_valid && bus.core_sr == SR_ACK);
    end

    // Outputs are decoded from the next state so they line up with it once registered.
    always_comb begin
        req_ready_d = 1'b0;
        busy_d      = 1'b1;
        core_cs_d   = 1'b1;
        core_adr_d  = ADR_SR;
        core_data_d = 8'h00;
        core_next_d = 1'b0;
        done_d      = 1'b0;
        err_d       = 1'b0;
        case (state_d)
            S_IDLE: begin
                req_ready_d = 1'b1;
                busy_d      = 1'b0;
                core_cs_d   = 1'b0;
                err_d       = bad_req;
            end
            S_LD_ADDR: begin
                core_adr_d  = ADR_TXR;
                core_data_d = {addr_d, 1'b0};
            end
            S_SET_START: begin
                core_adr_d  = ADR_CTR;
                core_data_d = 8'h03;
            end
            S_LD_BYTE: begin
                core_adr_d  = ADR_TXR;
                core_data_d = buf_q[7:0];
            end
            S_NEXT:  core_next_d = 1'b1;
            S_STOP: begin
                core_adr_d  = ADR_CTR;
                core_data_d = 8'h01;
            end
            S_FIN: begin
                done_d = 1'b1;
                err_d  = (err_code_q == 2'b01);
            end
            S_ABORT: begin
                core_adr_d  = ADR_CTR;
                core_data_d = 8'h00;
                done_d      = 1'b1;
                err_d       = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_q      <= '0;
            len_q       <= '0;
            idx_q       <= '0;
            buf_q       <= '0;
            cnt_q       <= '0;
            seen_q      <= 1'b0;
            err_code_q  <= 2'b00;
            req_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            core_adr_q  <= ADR_SR;
            core_data_q <= 8'h00;
            core_cs_q   <= 1'b0;
            core_next_q <= 1'b0;
        end else begin
            addr_q      <= addr_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            buf_q       <= buf_d;
            cnt_q       <= cnt_d;
            seen_q      <= seen_d;
            err_code_q  <= err_code_d;
            req_ready_q <= req_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            core_adr_q  <= core_adr_d;
            core_data_q <= core_data_d;
            core_cs_q   <= core_cs_d;
            core_next_q <= core_next_d;
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.err_code  = err_code_q;
    assign bus.core_adr  = core_adr_q;
    assign bus.core_data = core_data_q;
    assign bus.core_cs   = core_cs_q;
    assign bus.core_next = core_next_q;
endmodule

// File: tb/tb_iic_seq_ctrl.sv
// Directed bench for iic_seq_ctrl with a small behavioural I2C core model driving SR codes.
module tb_iic_seq_ctrl;
    localparam int NB  = 4;
    localparam int TMO = 15;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;

    bit   stuck = 1'b0;
    int   nack_at = -1;

    int txr_val[$], txr_cyc[$], ctr_val[$], ctr_cyc[$], next_cyc[$], done_cyc[$];

    iic_seq_ctrl_if #(.NBYTES(NB)) bif ();

    iic_seq_ctrl #(.NBYTES(NB), .TIMEOUT(TMO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Core model: start -> 0x09 briefly, each byte shifts as 0x0A then waits as 0x08,
    // then 0x09 (ack) or 0x0C (nack); stop shows 0x0C for a few cycles then 0x00.
    typedef enum {M_IDLE, M_START, M_SHIFT, M_ACKW, M_HOLD, M_STOPPING} mphase_t;
    mphase_t    m_ph;
    logic [7:0] m_sr;
    int         m_cnt;
    int         m_byte;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_sr        <= 8'h00;
            bif.core_sr <= 8'h00;
            m_ph        <= M_IDLE;
            m_cnt       <= 0;
            m_byte      <= 0;
        end else begin
            bif.core_sr <= m_sr;
            if (bif.core_cs && bif.core_adr == 2'b11) begin
                m_cnt <= 0;
                if (bif.core_data == 8'h03) begin
                    m_sr <= 8'h09; m_ph <= M_START; m_byte <= 0;
                end else if (bif.core_data == 8'h01) begin
                    m_sr <= 8'h0C; m_ph <= M_STOPPING;
                end else begin
                    m_sr <= 8'h00; m_ph <= M_IDLE;
                end
            end else if (bif.core_next) begin
                m_sr <= 8'h0A; m_ph <= M_SHIFT; m_cnt <= 0;
            end else begin
                m_cnt <= m_cnt + 1;
                case (m_ph)
                    M_START: if (!stuck && m_cnt == 1) begin
                        m_sr <= 8'h0A; m_ph <= M_SHIFT; m_cnt <= 0;
                    end
                    M_SHIFT: if (m_cnt == 3) begin
                        m_sr <= 8'h08; m_ph <= M_ACKW; m_cnt <= 0;
                    end
                    M_ACKW: if (m_cnt == 3) begin
                        m_sr   <= (m_byte == nack_at) ? 8'h0C : 8'h09;
                        m_byte <= m_byte + 1;
                        m_ph   <= M_HOLD;
                        m_cnt  <= 0;
                    end
                    M_STOPPING: if (m_cnt == 2) begin
                        m_sr <= 8'h00; m_ph <= M_IDLE;
                    end
                    default: ;
                endcase
            end
        end
    end

    always @(negedge clk) begin
        if (bif.core_adr == 2'b00) begin
            txr_val.push_back(int'(bif.core_data));
            txr_cyc.push_back(cyc);
        end
        if (bif.core_adr == 2'b11) begin
            ctr_val.push_back(int'(bif.core_data));
            ctr_cyc.push_back(cyc);
        end
        if (bif.core_next === 1'b1) next_cyc.push_back(cyc);
        if (bif.done === 1'b1) done_cyc.push_back(cyc);
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual === expected) n_pass++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    endtask

    function automatic int qget(input int q[$], input int i);
        if (i >= 0 && i < q.size()) return q[i];
        return -1;
    endfunction

    task automatic clearLog();
        txr_val.delete(); txr_cyc.delete(); ctr_val.delete(); ctr_cyc.delete();
        next_cyc.delete(); done_cyc.delete();
    endtask

    task automatic applyStimulus(input logic [6:0] a, input logic [2:0] l, input logic [31:0] d,
                                 input bit hold, output int t_acc);
        bit got;
        got   = 1'b0;
        t_acc = -1;
        @(negedge clk);
        bif.req_valid = 1'b1;
        bif.req_addr  = a;
        bif.req_len   = l;
        bif.req_data  = d;
        for (int k = 0; k < 400 && !got; k++) begin
            if (k > 0) @(negedge clk);
            if (bif.req_ready === 1'b1) begin
                got   = 1'b1;
                t_acc = cyc;
            end
        end
        checkOutput("accept_seen", 32'(got), 1);
        @(posedge clk);
        #1;
        if (!hold) bif.req_valid = 1'b0;
    endtask

    task automatic waitDone(output int t_done, output logic e, output logic [1:0] code);
        bit got;
        got    = 1'b0;
        t_done = -1;
        e      = 1'b0;
        code   = 2'b00;
        for (int k = 0; k < 400 && !got; k++) begin
            @(negedge clk);
            if (bif.done === 1'b1) begin
                got    = 1'b1;
                t_done = cyc;
                e      = bif.err;
                code   = bif.err_code;
            end
        end
        checkOutput("done_seen", 32'(got), 1);
        @(posedge clk);
        #1;
    endtask

    task automatic applyBad(input logic [2:0] l, input string tag);
        @(negedge clk);
        bif.req_valid = 1'b1;
        bif.req_addr  = 7'h11;
        bif.req_len   = l;
        checkOutput({tag, "_ready"}, 32'(bif.req_ready), 1);
        @(negedge clk);
        bif.req_valid = 1'b0;
        checkOutput({tag, "_err"}, 32'(bif.err), 1);
        checkOutput({tag, "_code"}, 32'(bif.err_code), 3);
        checkOutput({tag, "_busy"}, 32'(bif.busy), 0);
        checkOutput({tag, "_done"}, 32'(bif.done), 0);
        @(negedge clk);
        checkOutput({tag, "_err_clr"}, 32'(bif.err), 0);
        checkOutput({tag, "_code_held"}, 32'(bif.err_code), 3);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_ready"}, 32'(bif.req_ready), 0);
        checkOutput({tag, "_busy"}, 32'(bif.busy), 0);
        checkOutput({tag, "_done"}, 32'(bif.done), 0);
        checkOutput({tag, "_err"}, 32'(bif.err), 0);
        checkOutput({tag, "_code"}, 32'(bif.err_code), 0);
        checkOutput({tag, "_adr"}, 32'(bif.core_adr), 2);
        checkOutput({tag, "_data"}, 32'(bif.core_data), 0);
        checkOutput({tag, "_cs"}, 32'(bif.core_cs), 0);
        checkOutput({tag, "_next"}, 32'(bif.core_next), 0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int         t_acc, t_b, t_done;
        logic       e;
        logic [1:0] code;
        int         exp4[5];
        bit         hit;

        rst_n         = 1'b0;
        bif.req_valid = 1'b0;
        bif.req_addr  = '0;
        bif.req_len   = '0;
        bif.req_data  = '0;
        repeat (3) @(negedge clk);
        checkResetValues("rst");
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("rel_ready", 32'(bif.req_ready), 1);

        $display("[TB] single-byte write");
        clearLog();
        applyStimulus(7'h50, 3'd1, 32'h0000_00A5, 1'b0, t_acc);
        waitDone(t_done, e, code);
        checkOutput("t1_txr_cnt", txr_val.size(), 2);
        checkOutput("t1_txr_addr", qget(txr_val, 0), 32'hA0);
        checkOutput("t1_txr_addr_cyc", qget(txr_cyc, 0), t_acc + 1);
        checkOutput("t1_ctr_start", qget(ctr_val, 0), 32'h03);
        checkOutput("t1_ctr_start_cyc", qget(ctr_cyc, 0), t_acc + 2);
        checkOutput("t1_txr_data", qget(txr_val, 1), 32'hA5);
        checkOutput("t1_next_cnt", next_cyc.size(), 1);
        checkOutput("t1_next_cyc", qget(next_cyc, 0), qget(txr_cyc, 1) + 1);
        checkOutput("t1_ctr_stop", qget(ctr_val, 1), 32'h01);
        checkOutput("t1_err", 32'(e), 0);
        checkOutput("t1_code", 32'(code), 0);
        checkOutput("t1_done_cnt", done_cyc.size(), 1);

        $display("[TB] four-byte write");
        clearLog();
        exp4 = '{32'hA0, 32'h11, 32'h22, 32'h33, 32'h44};
        applyStimulus(7'h50, 3'd4, 32'h4433_2211, 1'b0, t_acc);
        waitDone(t_done, e, code);
        checkOutput("t2_txr_cnt", txr_val.size(), 5);
        for (int i = 0; i < 5; i++)
            checkOutput($sformatf("t2_txr%0d", i), qget(txr_val, i), exp4[i]);
        checkOutput("t2_next_cnt", next_cyc.size(), 4);
        for (int i = 0; i < 4; i++)
            checkOutput($sformatf("t2_next_cyc%0d", i), qget(next_cyc, i), qget(txr_cyc, i + 1) + 1);
        checkOutput("t2_done_cnt", done_cyc.size(), 1);
        checkOutput("t2_err", 32'(e), 0);

        $display("[TB] nack on byte 2 of 3");
        clearLog();
        nack_at = 2;
        applyStimulus(7'h3C, 3'd3, 32'h00CC_BBAA, 1'b0, t_acc);
        waitDone(t_done, e, code);
        nack_at = -1;
        checkOutput("t3_txr_cnt", txr_val.size(), 3);
        checkOutput("t3_txr_addr", qget(txr_val, 0), 32'h78);
        checkOutput("t3_txr_last", qget(txr_val, 2), 32'hBB);
        checkOutput("t3_ctr_cnt", ctr_val.size(), 2);
        checkOutput("t3_ctr_stop", qget(ctr_val, 1), 32'h01);
        checkOutput("t3_next_cnt", next_cyc.size(), 2);
        checkOutput("t3_err", 32'(e), 1);
        checkOutput("t3_code", 32'(code), 1);
        checkOutput("t3_done_cnt", done_cyc.size(), 1);

        $display("[TB] stuck SR timeout");
        clearLog();
        stuck = 1'b1;
        applyStimulus(7'h50, 3'd1, 32'h0000_0077, 1'b0, t_acc);
        waitDone(t_done, e, code);
        stuck = 1'b0;
        checkOutput("t4_ctr_cnt", ctr_val.size(), 2);
        checkOutput("t4_ctr_abort", qget(ctr_val, 1), 32'h00);
        checkOutput("t4_abort_cyc", qget(ctr_cyc, 1), t_acc + 3 + TMO + 1);
        checkOutput("t4_done_cyc", t_done, t_acc + 3 + TMO + 1);
        checkOutput("t4_txr_cnt", txr_val.size(), 1);
        checkOutput("t4_err", 32'(e), 1);
        checkOutput("t4_code", 32'(code), 2);

        $display("[TB] bad length");
        clearLog();
        applyBad(3'd0, "t5_len0");
        applyBad(3'd5, "t5_len5");
        @(posedge clk);
        #1;
        checkOutput("t5_core_writes", txr_val.size() + ctr_val.size(), 0);
        checkOutput("t5_done_cnt", done_cyc.size(), 0);

        $display("[TB] mid-transaction reset");
        clearLog();
        applyStimulus(7'h50, 3'd2, 32'h0000_BBAA, 1'b0, t_acc);
        hit = 1'b0;
        for (int k = 0; k < 100 && !hit; k++) begin
            @(negedge clk);
            if (bif.core_sr == 8'h08) hit = 1'b1;
        end
        checkOutput("t6_wack_seen", 32'(hit), 1);
        checkOutput("t6_busy_before", 32'(bif.busy), 1);
        rst_n = 1'b0;
        @(negedge clk);
        checkResetValues("t6_rst");
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] back-to-back requests");
        clearLog();
        applyStimulus(7'h21, 3'd1, 32'h0000_005A, 1'b1, t_acc);
        applyStimulus(7'h22, 3'd1, 32'h0000_006B, 1'b0, t_b);
        waitDone(t_done, e, code);
        checkOutput("t7_done_cnt", done_cyc.size(), 2);
        checkOutput("t7_accept_cyc", t_b, qget(done_cyc, 0) + 1);
        checkOutput("t7_txr_cnt", txr_val.size(), 4);
        checkOutput("t7_txr_b_addr", qget(txr_val, 2), 32'h44);
        checkOutput("t7_txr_b_cyc", qget(txr_cyc, 2), t_b + 1);
        checkOutput("t7_txr_b_data", qget(txr_val, 3), 32'h6B);
        checkOutput("t7_err", 32'(e), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/iic_seq_ctrl.md
# iic_seq_ctrl

Transaction sequencer for the single-master I2C core. Accepts one write request (7-bit slave address plus 1–4 data bytes) and drives the core's register port to run the whole transfer: TXR/CTR writes, SR polling, `next` pulses, NACK and timeout handling, and stop. It sits between a host requester and the I2C core, so the host never handles the core register map directly.

## Interface
- `NBYTES`, default 4: data-byte buffer depth; `req_len` is legal in the range 1..`NBYTES`.
- `TIMEOUT`, default 1023: maximum number of cycles spent in any SR-wait state.
- `clk` in 1: the single clock.
- `rst_n` in 1: reset, synchronous and active-low.
- `req_valid` in 1: a request is present.
- `req_ready` out 1: the block is idle and accepts a request.
- `req_addr` in 7: slave address.
- `req_len` in 3: number of data bytes.
- `req_data` in 8*`NBYTES`: data bytes; byte0 is `[7:0]` and is sent first.
- `busy` out 1: a transaction is in progress.
- `done` out 1: one-cycle completion pulse.
- `err` out 1: one-cycle error pulse, coincident with `done`, or alone for a rejected request.
- `err_code` out 2: 00 none, 01 NACK, 10 timeout, 11 bad length. Held until the next request is accepted.
- `core_adr` out 2: core register address. 00 TXR, 01 RXR, 10 SR, 11 CTR.
- `core_data` out 8: core write data.
- `core_cs` out 1: core select.
- `core_next` out 1: "new byte loaded" pulse to the core.
- `core_sr` in 8: core read data. Registered in the core; it reflects `core_adr` from the previous cycle.

## Operation
- The core writes TXR or CTR on every cycle in which `core_adr` is 00 or 11. `core_adr` therefore parks at 10 (SR, no side effect) in every state except the single write cycles listed below.
- CTR bits: bit0 = write mode, bit1 = start.
- SR codes: 0x00 idle, 0x09 start, 0x0A data, 0x08 waiting ack, 0x0C stop.
- All outputs are registered.

State machine:
- **IDLE**: `req_ready`=1, `core_adr`=10.
  - On `req_valid` with `req_len` in 1..`NBYTES`: latch address, length and data; clear the byte index; clear `err_code`; go to LD_ADDR.
  - On `req_valid` with a bad length: pulse `err`, set `err_code`=11, stay in IDLE, no core writes.
- **LD_ADDR** (1 cycle): `core_adr`=00, `core_data`={addr,1'b0}. Go to SET_START.
- **SET_START** (1 cycle): `core_adr`=11, `core_data`=0x03. Go to W_DATA.
- **W_DATA**: wait for `core_sr` ∈ {0x0A, 0x08}, then go to W_ACK.
- **W_ACK**: wait for `core_sr`=0x08, then watch the next code that differs from 0x08.
  - 0x09 means ACK. If bytes remain, go to LD_BYTE. Otherwise go to STOP.
  - 0x0C means NACK. Record NACK and go to STOP.
- **LD_BYTE** (1 cycle): `core_adr`=00, `core_data`=buffer[index]. Go to NEXT.
- **NEXT** (1 cycle): `core_adr`=10, `core_next`=1. Increment the index. Go to W_DATA.
- **STOP** (1 cycle): `core_adr`=11, `core_data`=0x01 (start cleared). Go to W_IDLE.
- **W_IDLE**: wait for `core_sr`=0x00, then go to FIN.
- **FIN** (1 cycle): pulse `done`; also pulse `err` if NACK was recorded (`err_code`=01). Go to IDLE.
- **ABORT** (1 cycle): `core_adr`=11, `core_data`=0x00. Pulse `done` and `err`, set `err_code`=10. Go to IDLE.

Common rules:
- `busy`=1 and `core_cs`=1 in every state except IDLE.
- The index counts from 0 up to `req_len`-1. The address byte does not count.

## Timing
- Reset: state IDLE; `core_adr`=10; `core_data`=0x00; `core_cs`, `core_next`, `busy`, `done`, `err` = 0; `err_code`=00; `req_ready`=0 while `rst_n` is low and 1 on the first cycle after release.
- Acceptance at cycle T gives: T+1 TXR write, T+2 CTR write, T+3 onward SR polling.
- SR sampling: on entry to any wait state, the first `core_sr` sample is ignored (one-cycle read latency).
- Timeout counter: cleared on entry to each wait state. When it reaches `TIMEOUT`, the next state is ABORT. The timeout has priority over a matching SR code in the same cycle.
- `core_next` is always exactly 1 cycle wide and always immediately follows the 1-cycle TXR write.
- `req_valid` while not in IDLE is ignored; the request is neither latched nor dropped silently, because `req_ready`=0.
- Reset mid-transaction: the next cycle shows reset values. The core is not sent a stop; the system resets the core together with this block.
- `done` and `err` are never asserted outside FIN, ABORT, or the bad-length cycle in IDLE.

## Test plan
- **Single-byte write.** addr 0x50, len 1, data 0xA5, with a core model that ACKs. Require: TXR written 0xA0 at T+1; CTR 0x03 at T+2; TXR 0xA5 then a 1-cycle `next`; CTR 0x01; `done`=1, `err`=0; `err_code`=00.
- **Four-byte write.** data 0x44332211, all ACKed. Require: TXR sequence 0xA0, 0x11, 0x22, 0x33, 0x44; exactly 4 `next` pulses; one `done`.
- **NACK on byte 2 of 3.** Require: after the 0x08→0x0C transition, CTR 0x01 is written; no third TXR write; `done`=`err`=1; `err_code`=01.
- **Stuck SR.** Core holds 0x09 and `TIMEOUT`=15. Require: ABORT with CTR 0x00 written 16 cycles after entering W_DATA; `err_code`=10.
- **Bad length.** `req_len`=0, then `req_len`=5. Require: one-cycle `err` with `err_code`=11 each time; `core_adr` stays 10 throughout; `busy`=0.
- **Mid-transaction reset, then back-to-back.** Assert `rst_n` low during W_ACK. Require: all outputs at reset values the next cycle. A request held on `req_valid` during `busy` is accepted only on the cycle after `done`.
